// File: rtl/aes_rcon_seq_pkg.sv
// aes_rcon_pkg: shared types and helpers for the AES round-constant sequencer.
// Key-size encoding, per-size word geometry (Nk, W), the reverse-start Rcon,
// and GF(2^8) doubling/halving used to step Rcon in either direction.
package aes_rcon_pkg;

  typedef enum logic [1:0] {
    KS_128 = 2'd0,
    KS_192 = 2'd1,
    KS_256 = 2'd2,
    KS_BAD = 2'd3
  } key_size_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic logic [3:0] nk_of(input key_size_t ks);
    case (ks)
      KS_128:  return 4'd4;
      KS_192:  return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [5:0] nwords_of(input key_size_t ks);
    case (ks)
      KS_128:  return 6'd44;
      KS_192:  return 6'd52;
      default: return 6'd60;
    endcase
  endfunction

  // Rcon value used by the last RotWord word of each key size
  function automatic logic [7:0] rc_last_of(input key_size_t ks);
    case (ks)
      KS_128:  return 8'h36;
      KS_192:  return 8'h80;
      default: return 8'h40;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  // Inverse of xtime: undo the conditional reduction, then shift right
  function automatic logic [7:0] inv_xtime(input logic [7:0] x);
    logic [7:0] t;
    t = x ^ 8'h1b;
    return x[0] ? {1'b1, t[7:1]} : {1'b0, x[7:1]};
  endfunction

endpackage

// File: rtl/aes_rcon_seq_if.sv
// aes_rcon_seq_if: word-descriptor handshake between the round-constant
// sequencer (master) and the key-expansion datapath (slave).
//   valid/ready  handshake; out = {rc,24'h0} on RotWord words
//   rot_en       RotWord+SubWord+Rcon applies to this word
//   sub_only     SubWord-only word (AES-256)
//   widx         current word index; last = final word of the sequence
interface aes_rcon_seq_if;
  logic        valid;
  logic        ready;
  logic [31:0] out;
  logic        rot_en;
  logic        sub_only;
  logic [5:0]  widx;
  logic        last;

  modport master (output valid, out, rot_en, sub_only, widx, last, input ready);
  modport slave  (input valid, out, rot_en, sub_only, widx, last, output ready);
endinterface

// File: rtl/aes_rcon_seq.sv
// aes_rcon_seq: AES-128/192/256 round-constant sequencer, forward or reverse
// word order, one expanded-key word per handshake.
//   clk, rst   clock; asynchronous active-high reset
//   kld        start/restart, samples key_size and dir
//   key_size   0=128, 1=192, 2=256, 3=illegal
//   dir        0 forward (Nk..W-1), 1 reverse (W-1..Nk)
//   bus        descriptor handshake (master side)
//   err        one-cycle pulse on a rejected kld
module aes_rcon_seq
  import aes_rcon_pkg::*;
#(
  parameter logic [2:0] KS_MASK    = 3'b111,
  parameter bit         REVERSE_EN = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  kld,
  input  logic [1:0]            key_size,
  input  logic                  dir,
  aes_rcon_seq_if.master        bus,
  output logic                  err
);

  state_t      state_q, state_n;
  key_size_t   ks_q, ks_n;
  logic        dir_q, dir_n;
  logic [5:0]  widx_q, widx_n;
  logic [2:0]  phase_q, phase_n;
  logic [7:0]  rc_q, rc_n;
  logic        err_q, err_n;

  key_size_t   ks_in;
  logic [3:0]  nk_in;
  logic [3:0]  ks_ok;
  logic        kld_legal;
  logic [3:0]  nk;
  logic [2:0]  nk_m1;
  logic [5:0]  end_idx;
  logic        running;
  logic        rot;
  logic        last;

  assign ks_in     = key_size_t'(key_size);
  assign nk_in     = nk_of(ks_in);
  // Mask widened so key_size==3 indexes a constant 0 bit
  assign ks_ok     = {1'b0, KS_MASK};
  assign kld_legal = ks_ok[key_size] && (!dir || REVERSE_EN);

  assign nk      = nk_of(ks_q);
  assign nk_m1   = 3'(nk - 4'd1);
  assign end_idx = dir_q ? {2'b00, nk} : (nwords_of(ks_q) - 6'd1);
  assign running = (state_q == RUN);
  // phase tracks widx mod Nk, so no divider is needed
  assign rot     = running && (phase_q == 3'd0);
  assign last    = running && (widx_q == end_idx);

  always_comb begin
    state_n = state_q;
    ks_n    = ks_q;
    dir_n   = dir_q;
    widx_n  = widx_q;
    phase_n = phase_q;
    rc_n    = rc_q;
    err_n   = 1'b0;
    if (kld) begin
      if (kld_legal) begin
        state_n = RUN;
        ks_n    = ks_in;
        dir_n   = dir;
        if (dir) begin
          // W-1 mod Nk is 3 for every key size
          widx_n  = nwords_of(ks_in) - 6'd1;
          phase_n = 3'd3;
          rc_n    = rc_last_of(ks_in);
        end else begin
          widx_n  = {2'b00, nk_in};
          phase_n = 3'd0;
          rc_n    = 8'h01;
        end
      end else begin
        err_n   = 1'b1;
        state_n = IDLE;
      end
    end else if (running && bus.ready) begin
      if (last) begin
        state_n = IDLE;
      end else if (!dir_q) begin
        widx_n  = widx_q + 6'd1;
        phase_n = (phase_q == nk_m1) ? 3'd0 : phase_q + 3'd1;
        if (rot) rc_n = xtime(rc_q);
      end else begin
        widx_n  = widx_q - 6'd1;
        phase_n = (phase_q == 3'd0) ? nk_m1 : phase_q - 3'd1;
        if (rot) rc_n = inv_xtime(rc_q);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ks_q    <= KS_128;
      dir_q   <= 1'b0;
      widx_q  <= '0;
      phase_q <= '0;
      rc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      ks_q    <= ks_n;
      dir_q   <= dir_n;
      widx_q  <= widx_n;
      phase_q <= phase_n;
      rc_q    <= rc_n;
      err_q   <= err_n;
    end
  end

  // Outputs are gated by RUN so IDLE always presents zeros
  assign bus.valid    = running;
  assign bus.rot_en   = rot;
  assign bus.sub_only = running && (nk == 4'd8) && (phase_q == 3'd4);
  assign bus.widx     = running ? widx_q : '0;
  assign bus.last     = last;
  assign bus.out      = rot ? {rc_q, 24'h0} : '0;
  assign err          = err_q;

endmodule

// File: tb/tb_aes_rcon_seq.sv
module tb_aes_rcon_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       kld;
  logic       kld2;
  logic [1:0] key_size;
  logic       dir;
  logic       err1;
  logic       err2;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [7:0] rtab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                             8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  aes_rcon_seq_if bus1 ();
  aes_rcon_seq_if bus2 ();

  aes_rcon_seq #(.KS_MASK(3'b111), .REVERSE_EN(1'b1)) dut (
    .clk      (clk),
    .rst      (rst),
    .kld      (kld),
    .key_size (key_size),
    .dir      (dir),
    .bus      (bus1),
    .err      (err1)
  );

  aes_rcon_seq #(.KS_MASK(3'b001), .REVERSE_EN(1'b1)) dut_m1 (
    .clk      (clk),
    .rst      (rst),
    .kld      (kld2),
    .key_size (key_size),
    .dir      (dir),
    .bus      (bus2),
    .err      (err2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [42:0] obs1();
    return {err1, bus1.valid, bus1.out, bus1.rot_en, bus1.sub_only, bus1.widx, bus1.last};
  endfunction

  function automatic logic [42:0] obs2();
    return {err2, bus2.valid, bus2.out, bus2.rot_en, bus2.sub_only, bus2.widx, bus2.last};
  endfunction

  function automatic int nk_tb(input int ks);
    return (ks == 0) ? 4 : (ks == 1) ? 6 : 8;
  endfunction

  function automatic int w_tb(input int ks);
    return (ks == 0) ? 44 : (ks == 1) ? 52 : 60;
  endfunction

  function automatic logic [42:0] exp_word(input int ks, input bit d, input int idx);
    int          nk;
    bit          rot;
    bit          sub;
    bit          lst;
    logic [31:0] o;
    nk  = nk_tb(ks);
    rot = (idx % nk) == 0;
    sub = (nk == 8) && ((idx % 8) == 4);
    o   = rot ? {rtab[idx / nk - 1], 24'h0} : 32'h0;
    lst = d ? (idx == nk) : (idx == w_tb(ks) - 1);
    return {1'b0, 1'b1, o, rot, sub, 6'(idx), lst};
  endfunction

  task automatic start(input int ks, input bit d);
    @(negedge clk);
    key_size = 2'(ks);
    dir      = d;
    kld      = 1'b1;
    @(negedge clk);
    kld      = 1'b0;
  endtask

  // Walk the sequence from its first word; stop_at >= 0 returns on that word
  // without handshaking it.
  task automatic walk(input int ks, input bit d, input bit bp, input int stop_at);
    int idx;
    int fin;
    int cyc;
    bit done;
    idx  = d ? w_tb(ks) - 1 : nk_tb(ks);
    fin  = d ? nk_tb(ks) : w_tb(ks) - 1;
    cyc  = 0;
    done = 1'b0;
    while (!done) begin
      check($sformatf("word_ks%0d_d%0d_idx%0d", ks, d, idx), 64'(obs1()), 64'(exp_word(ks, d, idx)));
      if (idx == stop_at) return;
      bus1.ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      cyc++;
      if (bus1.ready) begin
        if (idx == fin) done = 1'b1;
        else idx = d ? idx - 1 : idx + 1;
      end
      if (cyc > 400) begin
        check("timeout", 64'(cyc), 64'(0));
        bus1.ready = 1'b0;
        return;
      end
    end
    check($sformatf("idle_after_last_ks%0d_d%0d", ks, d), 64'(obs1()), 64'(0));
    bus1.ready = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    kld        = 1'b0;
    kld2       = 1'b0;
    key_size   = 2'd0;
    dir        = 1'b0;
    bus1.ready = 1'b0;
    bus2.ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_dut", 64'(obs1()), 64'(0));
    check("reset_dut_m1", 64'(obs2()), 64'(0));
    rst = 1'b0;

    // AES-128 forward, AES-256 forward, AES-192 reverse, AES-256 reverse
    start(0, 1'b0); walk(0, 1'b0, 1'b0, -1);
    start(2, 1'b0); walk(2, 1'b0, 1'b0, -1);
    start(1, 1'b1); walk(1, 1'b1, 1'b0, -1);
    start(2, 1'b1); walk(2, 1'b1, 1'b0, -1);

    // AES-128 forward with random backpressure
    start(0, 1'b0); walk(0, 1'b0, 1'b1, -1);

    // Restart at widx 20 of AES-256 into AES-128 reverse, handshake in same cycle
    start(2, 1'b0); walk(2, 1'b0, 1'b0, 20);
    key_size   = 2'd0;
    dir        = 1'b1;
    kld        = 1'b1;
    bus1.ready = 1'b1;
    @(negedge clk);
    kld        = 1'b0;
    walk(0, 1'b1, 1'b0, -1);

    // Asynchronous reset mid-run
    start(0, 1'b0);
    bus1.ready = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_async_valid", 64'(bus1.valid), 64'(0));
    check("rst_async_all", 64'(obs1()), 64'(0));
    @(negedge clk);
    rst        = 1'b0;
    bus1.ready = 1'b0;
    @(negedge clk);
    check("idle_after_rst", 64'(obs1()), 64'(0));

    // Masked key size on the 128-only instance
    key_size = 2'd2;
    dir      = 1'b0;
    kld2     = 1'b1;
    @(negedge clk);
    kld2     = 1'b0;
    check("mask_err_pulse", 64'({err2, bus2.valid}), 64'(2'b10));
    @(negedge clk);
    check("mask_err_clear", 64'({err2, bus2.valid}), 64'(2'b00));
    key_size = 2'd0;
    kld2     = 1'b1;
    @(negedge clk);
    kld2     = 1'b0;
    check("mask_legal_first", 64'(obs2()), 64'(exp_word(0, 1'b0, 4)));

    // key_size=3 aborts a running sequence
    start(0, 1'b0);
    check("pre_abort_first", 64'(obs1()), 64'(exp_word(0, 1'b0, 4)));
    key_size = 2'd3;
    kld      = 1'b1;
    @(negedge clk);
    kld      = 1'b0;
    check("ks3_err_pulse", 64'(obs1()), {21'h0, 1'b1, 42'h0});
    @(negedge clk);
    check("ks3_err_clear", 64'(obs1()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
